// File: rtl/ram_arb_pkg.sv
// Shared constants and the issue-stage (S1) command record for ram_arbiter.
// The S1 record is sized by the package width constants.
package ram_arb_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int ID_WIDTH_DEF   = 2;
  localparam int READ_LATENCY   = 3;

  typedef struct packed {
    logic                      valid;
    logic                      we;
    logic [ID_WIDTH_DEF-1:0]   id;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } s1_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant among (req_i & mask_i), searching upward from ptr_i with wrap.
// With RAM_ARB_FIXED_PRIO_EN defined the search always starts at index 0.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [NUM_REQ-1:0]  mask_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_WIDTH-1:0] gnt_id_o,
  output logic                gnt_valid_o
);

  localparam int IW = ID_WIDTH + 1;

  logic [NUM_REQ-1:0] elig_s;
  logic [IW-1:0]      start_s;
  logic [IW-1:0]      idx_s;

  assign elig_s = req_i & mask_i;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign start_s = '0;
`else
  assign start_s = {1'b0, ptr_i};
`endif

  always_comb begin
    gnt_o       = '0;
    gnt_id_o    = '0;
    gnt_valid_o = 1'b0;
    idx_s       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = start_s + IW'(i);
      if (idx_s >= IW'(NUM_REQ)) begin
        idx_s = idx_s - IW'(NUM_REQ);
      end
      if (!gnt_valid_o && elig_s[idx_s[ID_WIDTH-1:0]]) begin
        gnt_valid_o                   = 1'b1;
        gnt_o[idx_s[ID_WIDTH-1:0]]    = 1'b1;
        gnt_id_o                      = idx_s[ID_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: NUM_REQ requesters share one single-port RAM through issue stage S1;
// reads return 3 cycles after grant. Define RAM_ARB_FIXED_PRIO_EN for fixed priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [ADDR_WIDTH-1:0]         o_ram_address,
  output logic [DATA_WIDTH-1:0]         o_ram_data,
  output logic                          o_ram_we,
  output logic                          o_ram_oe,
  input  logic [DATA_WIDTH-1:0]         i_ram_data,
  output logic                          o_rvalid,
  output logic [ID_WIDTH-1:0]           o_rid,
  output logic [DATA_WIDTH-1:0]         o_rdata
);

  s1_cmd_t               s1_q, s1_d;
  logic                  oe_q, oe_d;
  logic                  s2_rd_q, s2_rd_d;
  logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;
  logic                  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [NUM_REQ-1:0]    mask_s;
  logic [NUM_REQ-1:0]    gnt_s;
  logic [ID_WIDTH-1:0]   gnt_id_s;
  logic [ID_WIDTH-1:0]   ptr_s;
  logic                  gnt_valid_s;
  logic                  accept_s;
  logic                  s1_rd_s;

  assign s1_rd_s = s1_q.valid & ~s1_q.we;
  // A write issued behind a read in S1 would drive the RAM during that read's capture cycle.
  assign mask_s  = ~(i_we & {NUM_REQ{s1_rd_s}});

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req_i       (i_req),
    .mask_i      (mask_s),
    .ptr_i       (ptr_s),
    .gnt_o       (gnt_s),
    .gnt_id_o    (gnt_id_s),
    .gnt_valid_o (gnt_valid_s)
  );

  assign o_gnt    = rst ? '0 : gnt_s;
  assign accept_s = gnt_valid_s & ~rst;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign ptr_s = '0;
`else
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (accept_s) begin
      ptr_d = (gnt_id_s == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id_s + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_s = ptr_q;
`endif

  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = accept_s;
    s1_d.we    = 1'b0;
    if (accept_s) begin
      s1_d.we   = i_we[gnt_id_s];
      s1_d.id   = gnt_id_s;
      s1_d.addr = i_addr[gnt_id_s*ADDR_WIDTH +: ADDR_WIDTH];
      s1_d.data = i_data[gnt_id_s*DATA_WIDTH +: DATA_WIDTH];
    end
    oe_d     = ~(accept_s & i_we[gnt_id_s]);
    s2_rd_d  = s1_rd_s;
    s2_id_d  = s1_q.id;
    rvalid_d = s2_rd_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    if (s2_rd_q) begin
      rid_d   = s2_id_q;
      rdata_d = i_ram_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      oe_q     <= 1'b0;
      s2_rd_q  <= 1'b0;
      s2_id_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      s1_q     <= s1_d;
      oe_q     <= oe_d;
      s2_rd_q  <= s2_rd_d;
      s2_id_q  <= s2_id_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_ram_address = s1_q.addr;
  assign o_ram_data    = s1_q.data;
  assign o_ram_we      = s1_q.valid & s1_q.we;
  assign o_ram_oe      = oe_q;
  assign o_rvalid      = rvalid_q;
  assign o_rid         = rid_q;
  assign o_rdata       = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model of grants, RAM port activity and in-order read returns.
module tb_ram_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int IW  = 2;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_req, i_we;
  logic [N*AW-1:0] i_addr;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]    o_gnt;
  logic [AW-1:0]   o_ram_address;
  logic [DW-1:0]   o_ram_data;
  logic            o_ram_we, o_ram_oe;
  logic [DW-1:0]   i_ram_data;
  logic            o_rvalid;
  logic [IW-1:0]   o_rid;
  logic [DW-1:0]   o_rdata;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_data(i_data),
    .o_gnt(o_gnt), .o_ram_address(o_ram_address), .o_ram_data(o_ram_data),
    .o_ram_we(o_ram_we), .o_ram_oe(o_ram_oe), .i_ram_data(i_ram_data),
    .o_rvalid(o_rvalid), .o_rid(o_rid), .o_rdata(o_rdata)
  );

  // Synchronous single-port RAM seen by the arbiter.
  logic [DW-1:0] mem      [256];
  logic [DW-1:0] init_val [256];
  logic          load_mem;
  logic [DW-1:0] ram_rd;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_val[a];
    end else begin
      if (o_ram_we) mem[o_ram_address] <= o_ram_data;
      if (o_ram_oe && !o_ram_we) ram_rd <= mem[o_ram_address];
    end
  end
  assign i_ram_data = ram_rd;

  // Reference model state.
  typedef struct { int due; int id; int data; } ret_t;
  ret_t          exp_q[$];
  logic [DW-1:0] ref_mem [256];
  int            m_ptr;
  bit            m_s1_valid, m_s1_read, m_s1_write, m_fresh;
  logic [AW-1:0] m_s1_addr;
  logic [DW-1:0] m_s1_data;

  bit            r_pend [N];
  bit            r_req  [N];
  bit            r_we   [N];
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_data [N];

  int            cyc, n_checks, n_pass;
  logic [N-1:0]  obs_gnt;
  logic          obs_rvalid;
  logic [IW-1:0] obs_rid;
  logic [DW-1:0] obs_rdata;
  logic [N-1:0]  gseq [8];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      i_req[k]           = r_pend[k] && r_req[k];
      i_we[k]            = r_we[k];
      i_addr[k*AW +: AW] = r_addr[k];
      i_data[k*DW +: DW] = r_data[k];
    end
  endtask

  task automatic set_cmd(int k, bit we, int addr, int data);
    r_pend[k] = 1'b1;
    r_req[k]  = 1'b1;
    r_we[k]   = we;
    r_addr[k] = AW'(addr);
    r_data[k] = DW'(data);
  endtask

  task automatic check_reset_vals();
    check("rst_gnt", o_gnt, 0);
    check("rst_rvalid", o_rvalid, 0);
    check("rst_rid", o_rid, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_ram_we", o_ram_we, 0);
    check("rst_ram_oe", o_ram_oe, 0);
    check("rst_ram_addr", o_ram_address, 0);
    check("rst_ram_data", o_ram_data, 0);
  endtask

  task automatic reset_phase(int ncyc);
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_ptr = 0; m_s1_valid = 0; m_s1_read = 0; m_s1_write = 0; m_fresh = 1;
    check_reset_vals();
    repeat (ncyc) begin
      @(posedge clk); #1;
      cyc++;
      check_reset_vals();
    end
    rst      = 1'b0;
    load_mem = 1'b0;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, then step past the edge.
  task automatic step();
    int w;
    bit cand [N];
    @(negedge clk);
    w = -1;
    for (int k = 0; k < N; k++) cand[k] = r_pend[k] && r_req[k] && !(m_s1_read && r_we[k]);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (w < 0 && cand[k]) w = k;
    end
    check("gnt", o_gnt, (w < 0) ? 0 : (1 << w));
    check("ram_we", o_ram_we, m_s1_write);
    check("ram_oe", o_ram_oe, m_fresh ? 0 : !m_s1_write);
    if (m_s1_valid) check("ram_addr", o_ram_address, m_s1_addr);
    if (m_s1_write) check("ram_data", o_ram_data, m_s1_data);
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      check("rvalid", o_rvalid, 1);
      check("rid", o_rid, exp_q[0].id);
      check("rdata", o_rdata, exp_q[0].data);
      void'(exp_q.pop_front());
    end else begin
      check("rvalid_idle", o_rvalid, 0);
    end
    obs_gnt = o_gnt; obs_rvalid = o_rvalid; obs_rid = o_rid; obs_rdata = o_rdata;
    m_s1_valid = (w >= 0);
    m_s1_read  = (w >= 0) && !r_we[w];
    m_s1_write = (w >= 0) && r_we[w];
    if (w >= 0) begin
      m_s1_addr = r_addr[w];
      m_s1_data = r_data[w];
      if (r_we[w]) ref_mem[r_addr[w]] = r_data[w];
      else exp_q.push_back('{cyc + LAT, w, int'(ref_mem[r_addr[w]])});
`ifdef RAM_ARB_FIXED_PRIO_EN
      m_ptr = 0;
`else
      m_ptr = (w + 1) % N;
`endif
      r_pend[w] = 1'b0;
      r_req[w]  = 1'b0;
    end
    m_fresh = 0;
    @(posedge clk); #1;
    cyc++;
    drive();
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) begin
      r_pend[k] = 0; r_req[k] = 0;
    end
    drive();
  endtask

  initial begin
    rst = 1'b1; load_mem = 1'b1;
    cyc = 0; n_checks = 0; n_pass = 0;
    for (int k = 0; k < N; k++) begin
      r_pend[k] = 0; r_req[k] = 0; r_we[k] = 0; r_addr[k] = '0; r_data[k] = '0;
    end
    drive();
    for (int a = 0; a < 256; a++) init_val[a] = DW'($urandom_range(0, 255));
    init_val[8'h10] = 8'hA5;
    for (int a = 0; a < 256; a++) ref_mem[a] = init_val[a];
    reset_phase(2);

    // Single read: requester 2 reads 0x10.
    set_cmd(2, 0, 8'h10, 0); drive();
    step();
    check("single_gnt", obs_gnt, 4'b0100);
    repeat (3) step();
    check("single_rvalid", obs_rvalid, 1);
    check("single_rid", obs_rid, 2);
    check("single_rdata", obs_rdata, 8'hA5);

    // Write then read to the same address, back to back.
    set_cmd(3, 1, 8'h7F, 8'h3C); drive();
    step();
    set_cmd(0, 0, 8'h7F, 0); drive();
    step();
    repeat (3) step();
    check("wr_rd_rvalid", obs_rvalid, 1);
    check("wr_rd_rid", obs_rid, 0);
    check("wr_rd_rdata", obs_rdata, 8'h3C);

    // Read-to-write turnaround bubble.
    set_cmd(0, 0, 8'h20, 0); drive();
    step();
    set_cmd(1, 1, 8'h21, 8'h5A); drive();
    step();
    check("turn_blocked", obs_gnt, 4'b0000);
    step();
    check("turn_granted", obs_gnt, 4'b0010);
    repeat (3) step();

    // Reset right after a read grant: no return, lowest index wins afterwards.
    set_cmd(2, 0, 8'h10, 0); drive();
    step();
    set_cmd(0, 0, 8'h10, 0);
    set_cmd(3, 0, 8'h7F, 0);
    drive();
    reset_phase(2);
    step();
    check("post_rst_gnt", obs_gnt, 4'b0001);
    repeat (4) step();

    // All four requesters reading back to back.
    reset_phase(1);
    for (int k = 0; k < N; k++) set_cmd(k, 0, k * 4, 0);
    drive();
    for (int i = 0; i < 8; i++) begin
      step();
      gseq[i] = obs_gnt;
      for (int k = 0; k < N; k++) if (!r_pend[k]) set_cmd(k, 0, k * 4 + i, 0);
      drive();
    end
`ifndef RAM_ARB_FIXED_PRIO_EN
    check("rot0", gseq[0], 4'b0001);
    check("rot1", gseq[1], 4'b0010);
    check("rot2", gseq[2], 4'b0100);
    check("rot3", gseq[3], 4'b1000);
    check("rot4", gseq[4], 4'b0001);
`endif
    clear_reqs();
    repeat (4) step();

`ifdef RAM_ARB_FIXED_PRIO_EN
    set_cmd(1, 0, 8'h01, 0); set_cmd(3, 0, 8'h03, 0); drive();
    for (int i = 0; i < 5; i++) begin
      step();
      check("fixed_prio", obs_gnt, 4'b0010);
      set_cmd(1, 0, 8'h01, 0); drive();
    end
    clear_reqs();
    repeat (4) step();
`endif

    // Random traffic with withdrawals and address collisions.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!r_pend[k] && $urandom_range(0, 1) == 1)
          set_cmd(k, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255));
        if (r_pend[k]) r_req[k] = ($urandom_range(0, 7) != 0);
      end
      drive();
      step();
    end
    clear_reqs();
    repeat (5) step();
    check("drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
